// File: rtl/err_metric_acc.sv
// Error-metric accumulator: compares an approximate multiplier's products against
// exact ones over a run of num_samples pairs through a two-stage pipeline.
module err_metric_acc #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_samples,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*W-1:0]            exact,
  input  logic [2*W-1:0]            apprx,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          err_count,
  output logic [2*W+CNT_W-1:0]      sum_ed_abs,
  output logic signed [2*W+CNT_W:0] sum_ed,
  output logic [2*W-1:0]            max_ed,
  output logic [CNT_W-1:0]          zero_exact_count
);

  localparam int PW = 2 * W;
  localparam int AW = PW + CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   num_r;
  logic [CNT_W-1:0]   acc_cnt_r;
  logic               in_ready_r;
  logic               busy_r;
  logic               done_r;
  logic               accept_s;
  logic               last_s;
  logic               clr_s;
  logic signed [PW:0] d_s;

  logic               s1_valid_r;
  logic signed [PW:0] s1_d_r;
  logic [PW-1:0]      s1_abs_r;
  logic               s1_mis_r;
  logic               s1_zero_r;

  logic [CNT_W-1:0]   err_cnt_r;
  logic [AW-1:0]      sum_abs_r;
  logic [AW:0]        sum_r;
  logic [PW-1:0]      max_r;
  logic [CNT_W-1:0]   zero_cnt_r;

  // Magnitude of a signed difference; |d| never exceeds 2^PW-1 so PW bits suffice.
  function automatic logic [PW-1:0] abs_ed(input logic signed [PW:0] d);
    logic [PW:0] mag;
    mag = d[PW] ? $unsigned(-d) : $unsigned(d);
    return mag[PW-1:0];
  endfunction

  assign accept_s = in_valid && in_ready_r;
  assign last_s   = accept_s && ((acc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) == num_r);
  assign d_s      = {1'b0, exact} - {1'b0, apprx};

  // Next-state decode; start is honoured only while idle or holding results.
  always_comb begin
    state_s = state_r;
    clr_s   = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          clr_s   = 1'b1;
          state_s = (num_samples == {CNT_W{1'b0}}) ? DONE : RUN;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      // Stage 2 absorbs the last sample on the cycle stage 1 empties.
      DRAIN: begin
        if (!s1_valid_r) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, registered handshake/status flags and sample counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      num_r      <= {CNT_W{1'b0}};
      acc_cnt_r  <= {CNT_W{1'b0}};
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == RUN);
      busy_r     <= (state_s == RUN) || (state_s == DRAIN);
      done_r     <= (state_s == DONE);
      if (clr_s) begin
        num_r     <= num_samples;
        acc_cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
        acc_cnt_r <= acc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Stage 1: per-sample difference, magnitude and classification flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_d_r     <= {(PW+1){1'b0}};
      s1_abs_r   <= {PW{1'b0}};
      s1_mis_r   <= 1'b0;
      s1_zero_r  <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_d_r    <= d_s;
        s1_abs_r  <= abs_ed(d_s);
        s1_mis_r  <= (exact != apprx);
        s1_zero_r <= (exact == {PW{1'b0}});
      end
    end
  end

  // Stage 2: accumulators sized so a full-length run cannot wrap.
  always_ff @(posedge clk) begin
    if (rst || clr_s) begin
      err_cnt_r  <= {CNT_W{1'b0}};
      sum_abs_r  <= {AW{1'b0}};
      sum_r      <= {(AW+1){1'b0}};
      max_r      <= {PW{1'b0}};
      zero_cnt_r <= {CNT_W{1'b0}};
    end else if (s1_valid_r) begin
      err_cnt_r  <= err_cnt_r + {{(CNT_W-1){1'b0}}, s1_mis_r};
      sum_abs_r  <= sum_abs_r + {{CNT_W{1'b0}}, s1_abs_r};
      sum_r      <= sum_r + {{CNT_W{s1_d_r[PW]}}, s1_d_r};
      zero_cnt_r <= zero_cnt_r + {{(CNT_W-1){1'b0}}, s1_zero_r};
      if (s1_abs_r > max_r) begin
        max_r <= s1_abs_r;
      end
    end
  end

  assign in_ready         = in_ready_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign err_count        = err_cnt_r;
  assign sum_ed_abs       = sum_abs_r;
  assign sum_ed           = $signed(sum_r);
  assign max_ed           = max_r;
  assign zero_exact_count = zero_cnt_r;

endmodule

// File: tb/tb_err_metric_acc.sv
// Self-checking bench for err_metric_acc: directed corner cases plus a long
// randomized run checked against a plain-arithmetic reference model.
module tb_err_metric_acc;
  localparam int W     = 8;
  localparam int CNT_W = 16;
  localparam int PW    = 2 * W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [CNT_W-1:0]        num_samples;
  logic                    in_valid;
  logic                    in_ready;
  logic [PW-1:0]           exact;
  logic [PW-1:0]           apprx;
  logic                    busy;
  logic                    done;
  logic [CNT_W-1:0]        err_count;
  logic [PW+CNT_W-1:0]     sum_ed_abs;
  logic signed [PW+CNT_W:0] sum_ed;
  logic [PW-1:0]           max_ed;
  logic [CNT_W-1:0]        zero_exact_count;

  int checks = 0;
  int errors = 0;

  // Reference totals for the current run.
  longint m_abs, m_sum, m_max;
  int     m_err, m_zero;

  err_metric_acc #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .exact(exact), .apprx(apprx),
    .busy(busy), .done(done), .err_count(err_count), .sum_ed_abs(sum_ed_abs),
    .sum_ed(sum_ed), .max_ed(max_ed), .zero_exact_count(zero_exact_count)
  );

  always #5 clk = ~clk;

  // Stand-in approximate multiplier: exact high bits, OR-approximated low nibble.
  function automatic logic [15:0] apprx_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    return {p[15:4], a[3:0] | b[3:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_abs = 0; m_sum = 0; m_max = 0; m_err = 0; m_zero = 0;
  endtask

  task automatic model_add(input longint e, input longint a);
    longint d, ad;
    d  = e - a;
    ad = (d < 0) ? -d : d;
    if (e != a) m_err++;
    if (e == 0) m_zero++;
    m_abs += ad;
    m_sum += d;
    if (ad > m_max) m_max = ad;
  endtask

  task automatic do_start(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    cyc();
    start       = 1'b0;
  endtask

  task automatic send_pair(input logic [PW-1:0] e, input logic [PW-1:0] a);
    int waited;
    exact    = e;
    apprx    = a;
    in_valid = 1'b1;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      cyc();
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end else begin
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && done !== 1'b1; i++) cyc();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%0b, required 1 within %0d cycles", done, bound);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; num_samples = 16'd3; in_valid = 1'b1;
    exact = 16'd5; apprx = 16'd1;
    cyc(); cyc();
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: ready/busy/done=%b, required 000", {in_ready, busy, done});
    end
    checks++;
    if (err_count !== 16'd0 || sum_ed_abs !== 32'd0 || sum_ed !== 33'sd0 ||
        max_ed !== 16'd0 || zero_exact_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_results: err=%0d abs=%0d sum=%0d max=%0d zero=%0d, required all 0",
               err_count, sum_ed_abs, sum_ed, max_ed, zero_exact_count);
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_directed();
    int unsigned ev[4] = '{100, 100, 50, 0};
    int unsigned av[4] = '{100, 96, 58, 0};
    do_start(4);
    for (int i = 0; i < 4; i++) begin
      exact = PW'(ev[i]); apprx = PW'(av[i]); in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed_ready[%0d]: in_ready=%0b, required 1", i, in_ready);
      end
      cyc();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL directed_ready_drop: in_ready=%0b, required 0", in_ready);
    end
    wait_done(10);
    checks++;
    if (err_count !== 16'd2) begin errors++; $display("FAIL directed_err: got %0d required 2", err_count); end
    checks++;
    if (sum_ed_abs !== 32'd12) begin errors++; $display("FAIL directed_abs: got %0d required 12", sum_ed_abs); end
    checks++;
    if (longint'(sum_ed) !== -64'sd4) begin errors++; $display("FAIL directed_sum: got %0d required -4", sum_ed); end
    checks++;
    if (max_ed !== 16'd8) begin errors++; $display("FAIL directed_max: got %0d required 8", max_ed); end
    checks++;
    if (zero_exact_count !== 16'd1) begin errors++; $display("FAIL directed_zero: got %0d required 1", zero_exact_count); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL directed_busy: got %0b required 0", busy); end
  endtask

  task automatic test_max_product();
    do_start(1);
    send_pair(16'd65025, 16'd0);
    wait_done(10);
    checks++;
    if (sum_ed_abs !== 32'd65025) begin errors++; $display("FAIL max_abs: got %0d required 65025", sum_ed_abs); end
    checks++;
    if (longint'(sum_ed) !== 64'sd65025) begin errors++; $display("FAIL max_sum: got %0d required 65025", sum_ed); end
    checks++;
    if (max_ed !== 16'd65025) begin errors++; $display("FAIL max_max: got %0d required 65025", max_ed); end
    checks++;
    if (err_count !== 16'd1) begin errors++; $display("FAIL max_err: got %0d required 1", err_count); end
  endtask

  task automatic test_zero_samples();
    bit seen_done = 1'b0;
    bit seen_ready = 1'b0;
    exact = 16'd7; apprx = 16'd3; in_valid = 1'b1;
    do_start(0);
    for (int i = 0; i < 3; i++) begin
      if (i < 2 && done === 1'b1) seen_done = 1'b1;
      if (in_ready !== 1'b0) seen_ready = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    checks++;
    if (!seen_done) begin errors++; $display("FAIL zero_done: done=%0b, required 1 within 2 cycles", done); end
    checks++;
    if (seen_ready) begin errors++; $display("FAIL zero_ready: in_ready asserted, required never"); end
    checks++;
    if (err_count !== 16'd0 || sum_ed_abs !== 32'd0 || sum_ed !== 33'sd0 ||
        max_ed !== 16'd0 || zero_exact_count !== 16'd0) begin
      errors++;
      $display("FAIL zero_results: err=%0d abs=%0d sum=%0d max=%0d zero=%0d, required all 0",
               err_count, sum_ed_abs, sum_ed, max_ed, zero_exact_count);
    end
  endtask

  task automatic test_bubbles();
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int acc = 0;
    int unsigned a, b;
    model_clear();
    do_start(3);
    for (int i = 0; i < 7; i++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      exact = PW'(a * b); apprx = apprx_mul(8'(a), 8'(b)); in_valid = pat[i];
      checks++;
      if (in_ready !== (acc < 3)) begin
        errors++;
        $display("FAIL bubble_ready[%0d]: in_ready=%0b required %0b", i, in_ready, (acc < 3));
      end
      if (pat[i] && acc < 3) begin
        model_add(longint'(a * b), longint'(apprx_mul(8'(a), 8'(b))));
        acc++;
      end
      if (i == 6) begin
        checks++;
        if ({busy, done} !== 2'b10) begin
          errors++;
          $display("FAIL bubble_drain1: busy/done=%b required 10", {busy, done});
        end
      end
      cyc();
    end
    in_valid = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin errors++; $display("FAIL bubble_drain2: busy/done=%b required 10", {busy, done}); end
    cyc();
    checks++;
    if ({busy, done} !== 2'b01) begin errors++; $display("FAIL bubble_done: busy/done=%b required 01", {busy, done}); end
    checks++;
    if (int'(err_count) !== m_err || longint'(sum_ed_abs) !== m_abs || longint'(sum_ed) !== m_sum ||
        longint'(max_ed) !== m_max || int'(zero_exact_count) !== m_zero) begin
      errors++;
      $display("FAIL bubble_results: err=%0d/%0d abs=%0d/%0d sum=%0d/%0d max=%0d/%0d zero=%0d/%0d (got/required)",
               err_count, m_err, sum_ed_abs, m_abs, sum_ed, m_sum, max_ed, m_max, zero_exact_count, m_zero);
    end
  endtask

  task automatic test_back_to_back();
    model_clear();
    do_start(3);
    send_pair(16'd200, 16'd100); model_add(200, 100);
    start = 1'b1; num_samples = 16'd0;
    exact = 16'd100; apprx = 16'd200; in_valid = 1'b1; model_add(100, 200);
    cyc();
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if ({busy, done, in_ready} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_start_ignored: busy/done/ready=%b required 101", {busy, done, in_ready});
    end
    send_pair(16'd50, 16'd150); model_add(50, 150);
    wait_done(10);
    checks++;
    if (int'(err_count) !== m_err || longint'(sum_ed_abs) !== m_abs || longint'(sum_ed) !== m_sum ||
        longint'(max_ed) !== m_max || int'(zero_exact_count) !== m_zero) begin
      errors++;
      $display("FAIL b2b_results: err=%0d/%0d abs=%0d/%0d sum=%0d/%0d max=%0d/%0d zero=%0d/%0d (got/required)",
               err_count, m_err, sum_ed_abs, m_abs, sum_ed, m_sum, max_ed, m_max, zero_exact_count, m_zero);
    end
  endtask

  task automatic test_reset_midrun();
    int unsigned a, b;
    do_start(5);
    send_pair(16'd900, 16'd3);
    send_pair(16'd0, 16'd77);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_flags: ready/busy/done=%b required 000", {in_ready, busy, done});
    end
    checks++;
    if (err_count !== 16'd0 || sum_ed_abs !== 32'd0 || sum_ed !== 33'sd0 ||
        max_ed !== 16'd0 || zero_exact_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_results: err=%0d abs=%0d sum=%0d max=%0d zero=%0d, required all 0",
               err_count, sum_ed_abs, sum_ed, max_ed, zero_exact_count);
    end
    cyc();
    checks++;
    if (sum_ed_abs !== 32'd0) begin errors++; $display("FAIL midrst_flushed: abs=%0d required 0", sum_ed_abs); end
    model_clear();
    do_start(2);
    for (int i = 0; i < 2; i++) begin
      a = $urandom_range(1, 255); b = $urandom_range(1, 255);
      send_pair(PW'(a * b), apprx_mul(8'(a), 8'(b)));
      model_add(longint'(a * b), longint'(apprx_mul(8'(a), 8'(b))));
    end
    wait_done(10);
    checks++;
    if (int'(err_count) !== m_err || longint'(sum_ed_abs) !== m_abs || longint'(sum_ed) !== m_sum ||
        longint'(max_ed) !== m_max || int'(zero_exact_count) !== m_zero) begin
      errors++;
      $display("FAIL midrst_rerun: err=%0d/%0d abs=%0d/%0d sum=%0d/%0d max=%0d/%0d zero=%0d/%0d (got/required)",
               err_count, m_err, sum_ed_abs, m_abs, sum_ed, m_sum, max_ed, m_max, zero_exact_count, m_zero);
    end
  endtask

  task automatic test_random();
    int unsigned a, b;
    model_clear();
    do_start(10000);
    for (int i = 0; i < 10000; i++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      send_pair(PW'(a * b), apprx_mul(8'(a), 8'(b)));
      model_add(longint'(a * b), longint'(apprx_mul(8'(a), 8'(b))));
      if ($urandom_range(0, 3) == 0) cyc();
    end
    wait_done(10);
    checks++;
    if (int'(err_count) !== m_err) begin errors++; $display("FAIL rand_err: got %0d required %0d", err_count, m_err); end
    checks++;
    if (longint'(sum_ed_abs) !== m_abs) begin errors++; $display("FAIL rand_abs: got %0d required %0d", sum_ed_abs, m_abs); end
    checks++;
    if (longint'(sum_ed) !== m_sum) begin errors++; $display("FAIL rand_sum: got %0d required %0d", sum_ed, m_sum); end
    checks++;
    if (longint'(max_ed) !== m_max) begin errors++; $display("FAIL rand_max: got %0d required %0d", max_ed, m_max); end
    checks++;
    if (int'(zero_exact_count) !== m_zero) begin errors++; $display("FAIL rand_zero: got %0d required %0d", zero_exact_count, m_zero); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_max_product();
    test_zero_samples();
    test_bubbles();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
